// File: rtl/ram_block_pipe.sv
// Simple-dual-port RAM with byte-strobed writes, selectable read latency (0/1/2)
// and a defined read-during-write collision behaviour. One clock domain.
module ram_block_pipe #(
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    rd_coll
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  if (DATA_WIDTH % 8 != 0) begin : gen_bad_width
    $error("ram_block_pipe: DATA_WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY > 2) begin : gen_bad_latency
    $error("ram_block_pipe: RD_LATENCY must be 0, 1 or 2");
  end

  // No reset on the array so it can map onto block RAM.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  rd_hit_wr;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_merge;
  logic [DATA_WIDTH-1:0] rd_word;

  // Read word as seen at the issue cycle, including the collision merge.
  always_comb begin
    wr_in_range = {1'b0, wr_addr} < DepthW;
    rd_in_range = {1'b0, rd_addr} < DepthW;
    rd_old      = '0;
    if (rd_in_range) begin
      rd_old = mem[rd_addr];
    end
    rd_hit_wr = rd_en & wr_en & rd_in_range & (rd_addr == wr_addr);
    rd_merge  = rd_old;
    for (int unsigned b = 0; b < NumBytes; b++) begin
      if (wr_strb[b]) begin
        rd_merge[8*b +: 8] = data_in[8*b +: 8];
      end
    end
    rd_word = (rd_hit_wr && (RDW_MODE == 1)) ? rd_merge : rd_old;
  end

  // Byte-strobed write; out-of-range addresses and reset cycles are dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && wr_in_range) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (wr_strb[b]) begin
          mem[wr_addr][8*b +: 8] <= data_in[8*b +: 8];
        end
      end
    end
  end

  if (RD_LATENCY == 0) begin : gen_lat0
    // Fully combinational read path; reset only suppresses the qualifiers.
    always_comb begin
      data_out = rd_en ? rd_word : '0;
      rd_valid = rd_en & ~rst;
      rd_coll  = rd_hit_wr & ~rst;
    end
  end else begin : gen_lat12
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;
    logic                  s1_coll;

    // Stage 1: capture the issue-cycle result; data loads only on a real read.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_data  <= '0;
        s1_valid <= 1'b0;
        s1_coll  <= 1'b0;
      end else begin
        s1_valid <= rd_en;
        s1_coll  <= rd_hit_wr;
        if (rd_en) begin
          s1_data <= rd_word;
        end
      end
    end

    if (RD_LATENCY == 1) begin : gen_out1
      assign data_out = s1_data;
      assign rd_valid = s1_valid;
      assign rd_coll  = s1_coll;
    end else begin : gen_out2
      logic [DATA_WIDTH-1:0] s2_data;
      logic                  s2_valid;
      logic                  s2_coll;

      // Stage 2: output register, holds data while no valid read arrives.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
          s2_coll  <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          s2_coll  <= s1_coll;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign data_out = s2_data;
      assign rd_valid = s2_valid;
      assign rd_coll  = s2_coll;
    end
  end

endmodule

// File: tb/tb_ram_block_pipe.sv
// Bench for ram_block_pipe: three configurations share one stimulus stream.
//   d0: latency 0, read-first, depth 1024
//   d1: latency 1, read-first, depth 1024
//   d2: latency 2, write-first, depth 1000
module tb_ram_block_pipe;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_strb;
  logic [9:0]  wr_addr;
  logic [31:0] data_in;
  logic        rd_en;
  logic [9:0]  rd_addr;

  logic [31:0] d0_data, d1_data, d2_data;
  logic        d0_valid, d1_valid, d2_valid;
  logic        d0_coll, d1_coll, d2_coll;

  ram_block_pipe #(.MEM_DEPTH(1024), .ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(0),
                   .RDW_MODE(0)) u_d0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_strb(wr_strb), .wr_addr(wr_addr),
    .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(d0_data),
    .rd_valid(d0_valid), .rd_coll(d0_coll)
  );
  ram_block_pipe #(.MEM_DEPTH(1024), .ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(1),
                   .RDW_MODE(0)) u_d1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_strb(wr_strb), .wr_addr(wr_addr),
    .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(d1_data),
    .rd_valid(d1_valid), .rd_coll(d1_coll)
  );
  ram_block_pipe #(.MEM_DEPTH(1000), .ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(2),
                   .RDW_MODE(1)) u_d2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_strb(wr_strb), .wr_addr(wr_addr),
    .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(d2_data),
    .rd_valid(d2_valid), .rd_coll(d2_coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        coll;
    int          due;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] model [1024];
  logic [31:0] last1 = '0;
  logic [31:0] last2 = '0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  function automatic logic exp_coll(input int unsigned depth);
    return rd_en && wr_en && (rd_addr == wr_addr) && (32'(rd_addr) < depth);
  endfunction

  function automatic logic [31:0] exp_word(input int unsigned depth, input int unsigned rdw);
    logic [31:0] w;
    if (32'(rd_addr) >= depth) return '0;
    w = model[rd_addr];
    if (rdw == 1 && exp_coll(depth)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) w[8*b +: 8] = data_in[8*b +: 8];
      end
    end
    return w;
  endfunction

  // Scoreboard: push expectations at each edge, compare registered outputs 1 time unit later.
  always @(posedge clk) begin : mon_edge
    exp_t e;
    cyc++;
    if (rst) begin
      q1.delete();
      q2.delete();
      last1 = '0;
      last2 = '0;
    end else begin
      if (rd_en) begin
        e.data = exp_word(1024, 0);
        e.coll = exp_coll(1024);
        e.due  = cyc;
        q1.push_back(e);
        e.data = exp_word(1000, 1);
        e.coll = exp_coll(1000);
        e.due  = cyc + 1;
        q2.push_back(e);
      end
      if (wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) model[wr_addr][8*b +: 8] = data_in[8*b +: 8];
        end
      end
    end
    #1;
    checks++;
    if (d1_valid) begin
      if (q1.size() == 0 || q1[0].due != cyc) begin
        errors++;
        $display("FAIL lat1_unexpected_valid cyc=%0d got data=%h, no read due", cyc, d1_data);
      end else begin
        e = q1.pop_front();
        if (d1_data !== e.data || d1_coll !== e.coll) begin
          errors++;
          $display("FAIL lat1_data cyc=%0d got %h coll=%b expected %h coll=%b",
                   cyc, d1_data, d1_coll, e.data, e.coll);
        end
        last1 = e.data;
      end
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      errors++;
      $display("FAIL lat1_missing_valid cyc=%0d got valid=0 expected valid=1", cyc);
      void'(q1.pop_front());
    end else if (d1_data !== last1 || d1_coll !== 1'b0) begin
      errors++;
      $display("FAIL lat1_hold cyc=%0d got %h coll=%b expected %h coll=0",
               cyc, d1_data, d1_coll, last1);
    end
    checks++;
    if (d2_valid) begin
      if (q2.size() == 0 || q2[0].due != cyc) begin
        errors++;
        $display("FAIL lat2_unexpected_valid cyc=%0d got data=%h, no read due", cyc, d2_data);
      end else begin
        e = q2.pop_front();
        if (d2_data !== e.data || d2_coll !== e.coll) begin
          errors++;
          $display("FAIL lat2_data cyc=%0d got %h coll=%b expected %h coll=%b",
                   cyc, d2_data, d2_coll, e.data, e.coll);
        end
        last2 = e.data;
      end
    end else if (q2.size() != 0 && q2[0].due <= cyc) begin
      errors++;
      $display("FAIL lat2_missing_valid cyc=%0d got valid=0 expected valid=1", cyc);
      void'(q2.pop_front());
    end else if (d2_data !== last2 || d2_coll !== 1'b0) begin
      errors++;
      $display("FAIL lat2_hold cyc=%0d got %h coll=%b expected %h coll=0",
               cyc, d2_data, d2_coll, last2);
    end
  end

  // Latency-0 outputs follow the current inputs; inputs are stable by the falling edge.
  always @(negedge clk) begin
    checks++;
    if (rst) begin
      if (d0_valid !== 1'b0 || d0_coll !== 1'b0) begin
        errors++;
        $display("FAIL lat0_reset got valid=%b coll=%b expected 0 0", d0_valid, d0_coll);
      end
    end else if (d0_valid !== rd_en || d0_coll !== exp_coll(1024) ||
                 d0_data !== (rd_en ? exp_word(1024, 0) : 32'h0)) begin
      errors++;
      $display("FAIL lat0_comb got %h valid=%b coll=%b expected %h valid=%b coll=%b",
               d0_data, d0_valid, d0_coll, rd_en ? exp_word(1024, 0) : 32'h0, rd_en,
               exp_coll(1024));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_strb = '0;
  endtask

  task automatic do_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en   = 1'b1;
    wr_addr = a;
    data_in = d;
    wr_strb = s;
  endtask

  task automatic do_rd(input logic [9:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    wr_addr = '0;
    rd_addr = '0;
    data_in = '0;
    step();
    step();
    checks++;
    if ({d0_valid, d1_valid, d2_valid, d0_coll, d1_coll, d2_coll} !== 6'b0 ||
        d0_data !== 32'h0 || d1_data !== 32'h0 || d2_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got d0=%h d1=%h d2=%h v=%b%b%b expected all zero",
               d0_data, d1_data, d2_data, d0_valid, d1_valid, d2_valid);
    end
    rst = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) begin
      do_wr(10'(i), 32'hC0DE_0000 | 32'(i), 4'hF);
      step();
    end
    do_wr(10'd498, 32'hC0DE_01F2, 4'hF);
    step();
    do_wr(10'd999, 32'hC0DE_03E7, 4'hF);
    step();
    idle();
  endtask

  task automatic test_basic();
    do_wr(10'd5, 32'hDEADBEEF, 4'hF);
    step();
    idle();
    do_rd(10'd5);
    #1;
    checks++;
    if (d0_data !== 32'hDEADBEEF || d0_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_lat0 got %h valid=%b expected deadbeef valid=1", d0_data, d0_valid);
    end
    step();
    idle();
    checks++;
    if (d1_data !== 32'hDEADBEEF || d1_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_lat1 got %h valid=%b expected deadbeef valid=1", d1_data, d1_valid);
    end
    step();
    checks++;
    if (d2_data !== 32'hDEADBEEF || d2_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_lat2 got %h valid=%b expected deadbeef valid=1", d2_data, d2_valid);
    end
  endtask

  task automatic test_strobe();
    do_wr(10'd3, 32'h11223344, 4'hF);
    step();
    do_wr(10'd3, 32'hAABBCCDD, 4'h5);
    step();
    idle();
    do_rd(10'd3);
    step();
    idle();
    checks++;
    if (d1_data !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strobe_lat1 got %h expected 11bb33dd", d1_data);
    end
    step();
    checks++;
    if (d2_data !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strobe_lat2 got %h expected 11bb33dd", d2_data);
    end
  endtask

  task automatic test_collision();
    do_wr(10'd7, 32'h0, 4'hF);
    step();
    do_wr(10'd7, 32'h12345678, 4'hF);
    do_rd(10'd7);
    #1;
    checks++;
    if (d0_data !== 32'h0 || d0_coll !== 1'b1) begin
      errors++;
      $display("FAIL coll_lat0 got %h coll=%b expected 0 coll=1", d0_data, d0_coll);
    end
    step();
    idle();
    checks++;
    if (d1_data !== 32'h0 || d1_coll !== 1'b1 || d1_valid !== 1'b1) begin
      errors++;
      $display("FAIL coll_read_first got %h coll=%b expected 0 coll=1", d1_data, d1_coll);
    end
    step();
    checks++;
    if (d2_data !== 32'h12345678 || d2_coll !== 1'b1 || d2_valid !== 1'b1) begin
      errors++;
      $display("FAIL coll_write_first got %h coll=%b expected 12345678 coll=1",
               d2_data, d2_coll);
    end
    do_rd(10'd7);
    step();
    idle();
    checks++;
    if (d1_data !== 32'h12345678 || d1_coll !== 1'b0) begin
      errors++;
      $display("FAIL coll_later_read got %h coll=%b expected 12345678 coll=0", d1_data, d1_coll);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_wr(10'(20 + i), 32'hB0B0_0000 | 32'(i), 4'hF);
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      do_rd(10'(20 + i));
      step();
      if (i >= 1) begin
        checks++;
        if (d2_valid !== 1'b1 || d2_data !== (32'hB0B0_0000 | 32'(i - 1))) begin
          errors++;
          $display("FAIL stream_lat2 idx=%0d got %h valid=%b expected %h valid=1",
                   i - 1, d2_data, d2_valid, 32'hB0B0_0000 | 32'(i - 1));
        end
      end
    end
    idle();
    step();
    checks++;
    if (d2_valid !== 1'b1 || d2_data !== 32'hB0B0_0003) begin
      errors++;
      $display("FAIL stream_last got %h valid=%b expected b0b00003 valid=1", d2_data, d2_valid);
    end
    step();
    checks++;
    if (d2_valid !== 1'b0 || d2_data !== 32'hB0B0_0003) begin
      errors++;
      $display("FAIL stream_hold got %h valid=%b expected b0b00003 valid=0", d2_data, d2_valid);
    end
  endtask

  task automatic test_out_of_range();
    do_wr(10'd1010, 32'h5A5A5A5A, 4'hF);
    step();
    idle();
    do_rd(10'd1010);
    step();
    idle();
    checks++;
    if (d1_data !== 32'h5A5A5A5A || d1_valid !== 1'b1) begin
      errors++;
      $display("FAIL oor_in_range_lat1 got %h valid=%b expected 5a5a5a5a", d1_data, d1_valid);
    end
    step();
    checks++;
    if (d2_data !== 32'h0 || d2_valid !== 1'b1 || d2_coll !== 1'b0) begin
      errors++;
      $display("FAIL oor_read got %h valid=%b expected 0 valid=1", d2_data, d2_valid);
    end
    do_rd(10'd999);
    step();
    do_rd(10'd10);
    step();
    do_rd(10'd498);
    step();
    idle();
    step();
    checks++;
    if (d2_data !== 32'hC0DE_01F2) begin
      errors++;
      $display("FAIL oor_unchanged got %h expected c0de01f2", d2_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_strb = 4'($urandom_range(0, 15));
      data_in = $urandom;
      wr_addr = ($urandom_range(0, 7) == 0) ? 10'd1010 : 10'($urandom_range(0, 15));
      rd_addr = ($urandom_range(0, 7) == 0) ? 10'd1010 : 10'($urandom_range(0, 15));
      step();
    end
    idle();
    step();
    step();
  endtask

  task automatic test_reset_midop();
    do_wr(10'd9, 32'hCAFEF00D, 4'hF);
    step();
    idle();
    do_rd(10'd9);
    step();
    idle();
    rst = 1'b1;
    do_wr(10'd9, 32'h0, 4'hF);
    step();
    rst = 1'b0;
    idle();
    checks++;
    if (d2_valid !== 1'b0 || d2_data !== 32'h0 || d1_valid !== 1'b0 || d1_data !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset got d1=%h v1=%b d2=%h v2=%b expected all zero",
               d1_data, d1_valid, d2_data, d2_valid);
    end
    step();
    checks++;
    if (d2_valid !== 1'b0) begin
      errors++;
      $display("FAIL midop_discard got valid=%b expected 0", d2_valid);
    end
    do_rd(10'd9);
    step();
    idle();
    step();
    checks++;
    if (d2_data !== 32'hCAFEF00D || d2_valid !== 1'b1) begin
      errors++;
      $display("FAIL midop_mem_kept got %h valid=%b expected cafef00d", d2_data, d2_valid);
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_basic();
    test_strobe();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_midop();
    idle();
    repeat (3) step();
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending reads expected 0/0", q1.size(), q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
